// File: rtl/char_step_sequencer_if.sv
// ---------------------------------------------------------------------------
// char_step_sequencer_if
//   Handshake bundle between the step sequencer and the character
//   physics / collision datapath.
//
//   detect_start  seq -> dp   1-cycle pulse: start collision/ground detection
//   detect_done   dp  -> seq  1-cycle pulse: detector results valid
//   step_en       seq -> dp   1-cycle pulse: physics registers advance one step
//   step_done     dp  -> seq  1-cycle pulse: step committed
//   evt_left      seq -> dp   left press seen since previous step
//   evt_right     seq -> dp   right press seen since previous step
//   evt_jump      seq -> dp   jump press seen since previous step
//   jump_held     seq -> dp   synchronized jump level
//
//   master : sequencer side
//   slave  : datapath side
// ---------------------------------------------------------------------------
interface char_step_sequencer_if;
    logic detect_start;
    logic detect_done;
    logic step_en;
    logic step_done;
    logic evt_left;
    logic evt_right;
    logic evt_jump;
    logic jump_held;

    modport master (
        output detect_start,
        output step_en,
        output evt_left,
        output evt_right,
        output evt_jump,
        output jump_held,
        input  detect_done,
        input  step_done
    );

    modport slave (
        input  detect_start,
        input  step_en,
        input  evt_left,
        input  evt_right,
        input  evt_jump,
        input  jump_held,
        output detect_done,
        output step_done
    );
endinterface

// File: rtl/char_step_sequencer.sv
// ---------------------------------------------------------------------------
// char_step_sequencer
//   Schedules one character physics update every FRAMES_PER_STEP vblank
//   rising edges: a DETECT phase (collision/ground detectors) followed by a
//   STEP phase (physics register update). Button presses are captured as
//   sticky edges between steps and handed to the datapath as evt_* at each
//   step, so a press is never lost however long a step takes.
//
// Ports
//   sys_clk       system clock
//   sys_rst_n     asynchronous reset, active-low
//   frame_vblank  vblank level from the VGA timing block (sys_clk domain)
//   left_btn      raw button, asynchronous
//   right_btn     raw button, asynchronous
//   jump_btn      raw button, asynchronous
//   seq_if        handshake bundle to the physics/collision datapath
//   busy          high whenever the FSM is not IDLE
//   timeout_flag  sticky: a phase timed out waiting for its done pulse
//   overrun_cnt   saturating count of ticks dropped while busy
//
// FSM
//   state      | meaning
//   -----------+-----------------------------------------------------
//   IDLE       | waiting for a frame tick
//   DETECT     | detect_start pulse, timer cleared
//   WAIT_DET   | waiting for detect_done or timeout
//   STEP       | step_en pulse, evt_* snapshot, sticky latches cleared
//   WAIT_STEP  | waiting for step_done or timeout
// ---------------------------------------------------------------------------
module char_step_sequencer #(
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter int unsigned TIMEOUT_CYC     = 1024,
    parameter int unsigned OVR_W           = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  frame_vblank,
    input  logic                  left_btn,
    input  logic                  right_btn,
    input  logic                  jump_btn,
    char_step_sequencer_if.master seq_if,
    output logic                  busy,
    output logic                  timeout_flag,
    output logic [OVR_W-1:0]      overrun_cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       FRAME_LAST = 4'(FRAMES_PER_STEP - 1);
    localparam logic [OVR_W-1:0] OVR_MAX    = {OVR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DETECT    = 3'd1,
        S_WAIT_DET  = 3'd2,
        S_STEP      = 3'd3,
        S_WAIT_STEP = 3'd4
    } state_t;

    // Button index order in the packed vectors below: 0 left, 1 right, 2 jump
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_J = 2;

    state_t                 state_q, state_d;
    logic                   vblank_dly_q, vblank_dly_d;
    logic [3:0]             frame_cnt_q, frame_cnt_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   timeout_flag_q, timeout_flag_d;
    logic [OVR_W-1:0]       overrun_cnt_q, overrun_cnt_d;
    logic [2:0][2:0]        btn_sync_q, btn_sync_d;
    logic [2:0]             latch_q, latch_d;
    logic [2:0]             evt_q, evt_d;

    logic [2:0]             btn_raw;
    logic [2:0]             btn_rise;
    logic                   vblank_rise;
    logic                   tick;
    logic                   timer_last;
    logic                   detect_start_o;
    logic                   step_en_o;
    logic                   busy_o;

    assign btn_raw    = {jump_btn, right_btn, left_btn};
    assign timer_last = (timer_q == TMR_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A done pulse wins over a simultaneous timeout, so
    // a late-but-valid completion never raises the sticky flag.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_DETECT;
            end
            S_DETECT: begin
                state_d = S_WAIT_DET;
            end
            S_WAIT_DET: begin
                if (seq_if.detect_done || timer_last) state_d = S_STEP;
            end
            S_STEP: begin
                state_d = S_WAIT_STEP;
            end
            S_WAIT_STEP: begin
                if (seq_if.step_done || timer_last) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        detect_start_o = 1'b0;
        step_en_o      = 1'b0;
        busy_o         = 1'b1;
        case (state_q)
            S_IDLE:   busy_o         = 1'b0;
            S_DETECT: detect_start_o = 1'b1;
            S_STEP:   step_en_o      = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vblank_dly_q   <= 1'b0;
            frame_cnt_q    <= '0;
            timer_q        <= '0;
            timeout_flag_q <= 1'b0;
            overrun_cnt_q  <= '0;
            btn_sync_q     <= '0;
            latch_q        <= '0;
            evt_q          <= '0;
        end else begin
            vblank_dly_q   <= vblank_dly_d;
            frame_cnt_q    <= frame_cnt_d;
            timer_q        <= timer_d;
            timeout_flag_q <= timeout_flag_d;
            overrun_cnt_q  <= overrun_cnt_d;
            btn_sync_q     <= btn_sync_d;
            latch_q        <= latch_d;
            evt_q          <= evt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame divider: tick on the vblank edge that wraps the count to 0
    // ------------------------------------------------------------------
    always_comb begin
        vblank_dly_d = frame_vblank;
        vblank_rise  = frame_vblank & ~vblank_dly_q;
        frame_cnt_d  = frame_cnt_q;
        tick         = 1'b0;
        if (vblank_rise) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                tick        = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase timer and sticky timeout flag. The timer free-runs in the WAIT
    // states and is re-zeroed by the DETECT/STEP cycle that precedes them.
    // ------------------------------------------------------------------
    always_comb begin
        timer_d        = timer_q;
        timeout_flag_d = timeout_flag_q;
        case (state_q)
            S_DETECT, S_STEP: begin
                timer_d = '0;
            end
            S_WAIT_DET: begin
                timer_d = timer_q + TMR_W'(1);
                if (!seq_if.detect_done && timer_last) timeout_flag_d = 1'b1;
            end
            S_WAIT_STEP: begin
                timer_d = timer_q + TMR_W'(1);
                if (!seq_if.step_done && timer_last) timeout_flag_d = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Overrun counter: any tick the FSM cannot accept, including the tick
    // that lands on the WAIT_STEP -> IDLE transition cycle.
    // ------------------------------------------------------------------
    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (tick && (state_q != S_IDLE) && (overrun_cnt_q != OVR_MAX)) begin
            overrun_cnt_d = overrun_cnt_q + OVR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizers, sticky press latches and event snapshot.
    // Stages [0] and [1] are the synchronizer; [2] only delays [1] for the
    // edge detector. In the STEP cycle the snapshot takes the old latch
    // value, and an edge arriving in that same cycle lands in the freshly
    // cleared latch so it is reported on the following step.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            btn_sync_d[i] = {btn_sync_q[i][1:0], btn_raw[i]};
            btn_rise[i]   = btn_sync_q[i][1] & ~btn_sync_q[i][2];
        end
        if (state_q == S_STEP) begin
            evt_d   = latch_q;
            latch_d = btn_rise;
        end else begin
            evt_d   = evt_q;
            latch_d = latch_q | btn_rise;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign seq_if.detect_start = detect_start_o;
    assign seq_if.step_en      = step_en_o;
    assign seq_if.evt_left     = evt_q[BTN_L];
    assign seq_if.evt_right    = evt_q[BTN_R];
    assign seq_if.evt_jump     = evt_q[BTN_J];
    assign seq_if.jump_held    = btn_sync_q[BTN_J][1];
    assign busy                = busy_o;
    assign timeout_flag        = timeout_flag_q;
    assign overrun_cnt         = overrun_cnt_q;

endmodule

// File: tb/tb_char_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_char_step_sequencer
//   dut_a: FRAMES_PER_STEP=2, TIMEOUT_CYC=16   (stepping, events, timeout, reset)
//   dut_b: FRAMES_PER_STEP=1, TIMEOUT_CYC=1024 (overrun saturation)
//   Expected evt_* triples are queued when the ticking vblank is driven and
//   compared one cycle after each step_en pulse of dut_a.
// ---------------------------------------------------------------------------
module tb_char_step_sequencer;

    localparam int FPS_A = 2;

    logic       sys_clk;
    logic       sys_rst_n;

    logic       a_vbl, a_left, a_right, a_jump;
    logic       a_busy, a_tmo;
    logic [7:0] a_ovr;
    logic       b_vbl, b_left, b_right, b_jump;
    logic       b_busy, b_tmo;
    logic [7:0] b_ovr;

    char_step_sequencer_if a_if ();
    char_step_sequencer_if b_if ();

    char_step_sequencer #(.FRAMES_PER_STEP(2), .TIMEOUT_CYC(16), .OVR_W(8)) dut_a (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .frame_vblank (a_vbl),
        .left_btn     (a_left),
        .right_btn    (a_right),
        .jump_btn     (a_jump),
        .seq_if       (a_if),
        .busy         (a_busy),
        .timeout_flag (a_tmo),
        .overrun_cnt  (a_ovr)
    );

    char_step_sequencer #(.FRAMES_PER_STEP(1), .TIMEOUT_CYC(1024), .OVR_W(8)) dut_b (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .frame_vblank (b_vbl),
        .left_btn     (b_left),
        .right_btn    (b_right),
        .jump_btn     (b_jump),
        .seq_if       (b_if),
        .busy         (b_busy),
        .timeout_flag (b_tmo),
        .overrun_cnt  (b_ovr)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    int a_n_det = 0;
    int a_n_step = 0;
    int a_last_done = 0;
    int a_last_start = 0;
    int a_last_step = 0;
    int b_n_step = 0;

    bit det_resp_on = 1'b1;
    bit step_resp_on = 1'b1;
    bit chk_lat = 1'b1;

    int         a_frames = 0;
    logic       exp_l = 1'b0, exp_r = 1'b0, exp_j = 1'b0;
    logic [2:0] sb_q[$];

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // One-cycle vblank pulse on dut_a; the frame model queues the expected
    // event snapshot whenever this pulse is the one that should tick.
    task automatic vbl_pulse();
        a_vbl = 1'b1;
        a_frames++;
        if (a_frames == FPS_A) begin
            a_frames = 0;
            sb_q.push_back({exp_l, exp_r, exp_j});
            exp_l = 1'b0;
            exp_r = 1'b0;
            exp_j = 1'b0;
        end
        step();
        a_vbl = 1'b0;
    endtask

    task automatic do_step_frames();
        vbl_pulse();
        repeat (9) step();
        vbl_pulse();
        repeat (29) step();
    endtask

    task automatic wait_step_a(input int max_cyc);
        int n0;
        int k;
        n0 = a_n_step;
        k  = 0;
        while (a_n_step == n0 && k < max_cyc) begin
            step();
            k++;
        end
        chk("wait_step_en", 32'(a_n_step != n0), 1);
    endtask

    // Detector / physics responders for dut_a: done 3 cycles after start
    initial begin
        a_if.detect_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (a_if.detect_start && det_resp_on) begin
                repeat (3) @(posedge sys_clk);
                #1 a_if.detect_done = 1'b1;
                @(posedge sys_clk);
                #1 a_if.detect_done = 1'b0;
            end
        end
    end

    initial begin
        a_if.step_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (a_if.step_en && step_resp_on) begin
                repeat (3) @(posedge sys_clk);
                #1 a_if.step_done = 1'b1;
                @(posedge sys_clk);
                #1 a_if.step_done = 1'b0;
            end
        end
    end

    // dut_b detector answers after 1 cycle; step_done is never returned
    initial begin
        b_if.detect_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (b_if.detect_start) begin
                @(posedge sys_clk);
                #1 b_if.detect_done = 1'b1;
                @(posedge sys_clk);
                #1 b_if.detect_done = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (b_if.step_en) b_n_step++;
        end
    end

    // dut_a monitor and scoreboard consumer
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge sys_clk);
            if (a_if.detect_done) a_last_done = cyc;
            if (a_if.detect_start) begin
                a_n_det++;
                a_last_start = cyc;
            end
            if (a_if.step_en) begin
                a_n_step++;
                a_last_step = cyc;
                if (chk_lat) chk("done_to_step_en", 32'(cyc - a_last_done), 1);
                @(negedge sys_clk);
                chk("sb_pending", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("evt_snapshot", 32'({a_if.evt_left, a_if.evt_right, a_if.evt_jump}), 32'(e));
                end
            end
        end
    end

    initial begin
        int n_det0;
        int n_step0;
        int n0;

        sys_rst_n = 1'b0;
        a_vbl = 1'b0; a_left = 1'b0; a_right = 1'b0; a_jump = 1'b0;
        b_vbl = 1'b0; b_left = 1'b0; b_right = 1'b0; b_jump = 1'b0;
        b_if.step_done = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_timeout", 32'(a_tmo), 0);
        chk("rst_overrun", 32'(a_ovr), 0);
        chk("rst_detect_start", 32'(a_if.detect_start), 0);
        chk("rst_step_en", 32'(a_if.step_en), 0);
        chk("rst_evt", 32'({a_if.evt_left, a_if.evt_right, a_if.evt_jump}), 0);
        chk("rst_jump_held", 32'(a_if.jump_held), 0);
        chk("rst_b_busy", 32'(b_busy), 0);
        sys_rst_n = 1'b1;
        repeat (2) step();

        // 1) four vblanks at two frames per step -> two full steps
        n_det0  = a_n_det;
        n_step0 = a_n_step;
        repeat (4) begin
            vbl_pulse();
            repeat (19) step();
        end
        chk("t1_detect_starts", 32'(a_n_det - n_det0), 2);
        chk("t1_step_ens", 32'(a_n_step - n_step0), 2);
        chk("t1_overrun", 32'(a_ovr), 0);
        chk("t1_idle", 32'(a_busy), 0);

        // 2) left press between steps, held for exactly one step period
        a_left = 1'b1;
        repeat (5) step();
        a_left = 1'b0;
        exp_l = 1'b1;
        repeat (4) step();
        do_step_frames();
        chk("t2_evt_left_held", 32'(a_if.evt_left), 1);
        chk("t2_evt_right", 32'(a_if.evt_right), 0);
        chk("t2_evt_jump", 32'(a_if.evt_jump), 0);
        vbl_pulse();
        repeat (9) step();
        chk("t2_evt_left_mid", 32'(a_if.evt_left), 1);
        vbl_pulse();
        repeat (29) step();
        chk("t2_evt_left_cleared", 32'(a_if.evt_left), 0);

        // 3) jump edge lands in the STEP cycle -> reported one step later
        vbl_pulse();
        repeat (9) step();
        vbl_pulse();
        step();
        step();
        a_jump = 1'b1;
        exp_j = 1'b1;
        repeat (4) step();
        chk("t3_jump_held", 32'(a_if.jump_held), 1);
        a_jump = 1'b0;
        repeat (25) step();
        chk("t3_evt_jump_this", 32'(a_if.evt_jump), 0);
        do_step_frames();
        chk("t3_evt_jump_next", 32'(a_if.evt_jump), 1);

        // 4) detect_done withheld -> timeout, then normal stepping resumes
        det_resp_on = 1'b0;
        chk_lat = 1'b0;
        n_step0 = a_n_step;
        do_step_frames();
        chk("t4_step_count", 32'(a_n_step - n_step0), 1);
        chk("t4_timeout_latency", 32'(a_last_step - a_last_start), 17);
        chk("t4_timeout_flag", 32'(a_tmo), 1);
        det_resp_on = 1'b1;
        chk_lat = 1'b1;
        n_step0 = a_n_step;
        do_step_frames();
        chk("t4_recover_step", 32'(a_n_step - n_step0), 1);
        chk("t4_timeout_sticky", 32'(a_tmo), 1);
        chk("t4_idle", 32'(a_busy), 0);

        // 6) reset during WAIT_STEP with events latched
        a_left = 1'b1;
        repeat (3) step();
        a_left = 1'b0;
        exp_l = 1'b1;
        repeat (3) step();
        step_resp_on = 1'b0;
        vbl_pulse();
        repeat (5) step();
        vbl_pulse();
        wait_step_a(20);
        a_right = 1'b1;
        repeat (3) step();
        a_right = 1'b0;
        step();
        chk("t6_pre_evt_left", 32'(a_if.evt_left), 1);
        chk("t6_pre_busy", 32'(a_busy), 1);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_evt", 32'({a_if.evt_left, a_if.evt_right, a_if.evt_jump}), 0);
        chk("t6_rst_busy", 32'(a_busy), 0);
        chk("t6_rst_timeout", 32'(a_tmo), 0);
        chk("t6_rst_detect_start", 32'(a_if.detect_start), 0);
        chk("t6_rst_step_en", 32'(a_if.step_en), 0);
        a_frames = 0;
        exp_l = 1'b0;
        exp_r = 1'b0;
        exp_j = 1'b0;
        repeat (3) step();
        sys_rst_n = 1'b1;
        step_resp_on = 1'b1;
        repeat (2) step();
        n_det0 = a_n_det;
        do_step_frames();
        chk("t6_clean_detect", 32'(a_n_det - n_det0), 1);
        chk("t6_no_timeout", 32'(a_tmo), 0);

        // 5) dut_b: step_done withheld across 300 ticks -> overrun saturates
        n0 = b_n_step;
        repeat (100) begin
            b_vbl = 1'b1;
            step();
            b_vbl = 1'b0;
            step();
        end
        chk("t5_overrun_100", 32'(b_ovr), 99);
        repeat (200) begin
            b_vbl = 1'b1;
            step();
            b_vbl = 1'b0;
            step();
        end
        chk("t5_overrun_sat", 32'(b_ovr), 255);
        chk("t5_one_step", 32'(b_n_step - n0), 1);
        chk("t5_still_busy", 32'(b_busy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
